pipelined_shifter: RTL and testbench

Parametrised, fully pipelined shifter/rotator with valid/ready handshake on input and output. It supersedes the ad-hoc combinational `>>` used in shift datapaths. It supports logical right, logical left, arithmetic right and (optionally) rotate right at one result per clock. It sits between an operand source and any consumer that may apply backpressure.

---
 rtl/pipelined_shifter.sv | 137 +++++++++++++
 tb/tb_pipelined_shifter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: SW-stage shifter/rotator with valid/ready on both sides.
// Stage i shifts by 2^i when bit i of the shift amount is set, so a full
// shift of 0..WIDTH-1 completes after SW register stages.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The pipe has a single global stall (out_valid & ~out_ready); while it
// is high every stage holds and in_ready is low. Outputs only change on an
// edge where no stall is present, so they stay stable under backpressure.
//
// Optional feature macro: PIPELINED_SHIFTER_ROTATE_EN
//   defined     -> mode 2'b11 rotates right
//   not defined -> mode 2'b11 behaves exactly as logical shift right

module pipelined_shifter #(
   parameter int WIDTH = 8,
   parameter int SW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SW-1:0]    in_amt,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zero
);

   localparam logic [1:0] MODE_LSR = 2'b00;
   localparam logic [1:0] MODE_LSL = 2'b01;
   localparam logic [1:0] MODE_ASR = 2'b10;
   localparam logic [1:0] MODE_ROR = 2'b11;

   // One stage worth of shifting by a fixed distance sh (0 < sh < WIDTH).
   // sgn is the MSB of the original operand, used as the ASR fill bit.
   function automatic logic [WIDTH-1:0] shift_step(
      input logic [WIDTH-1:0] x,
      input logic [1:0]       m,
      input logic             sgn,
      input int               sh
   );
      logic [WIDTH-1:0] r;
      logic [WIDTH-1:0] fill;
      fill = {WIDTH{sgn}} << (WIDTH - sh);
      case (m)
         MODE_LSR: r = x >> sh;
         MODE_LSL: r = x << sh;
         MODE_ASR: r = fill | (x >> sh);
         MODE_ROR: begin
`ifdef PIPELINED_SHIFTER_ROTATE_EN
            r = (x >> sh) | (x << (WIDTH - sh));
`else
            r = x >> sh;
`endif
         end
         default:  r = x >> sh;
      endcase
      return r;
   endfunction

   // Stage registers: entry i is the output of stage i.
   logic             v_q [SW];
   logic [WIDTH-1:0] d_q [SW];
   logic [SW-1:0]    a_q [SW];
   logic [1:0]       m_q [SW];
   logic             s_q [SW];
   logic             z_q;

   // Stage inputs (either the block input or the previous stage) and the
   // shifted data each stage will capture.
   logic             src_v [SW];
   logic [WIDTH-1:0] src_d [SW];
   logic [SW-1:0]    src_a [SW];
   logic [1:0]       src_m [SW];
   logic             src_s [SW];
   logic [WIDTH-1:0] nxt_d [SW];

   logic stall;

   assign stall     = v_q[SW-1] & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = v_q[SW-1];
   assign out_data  = d_q[SW-1];
   assign out_zero  = z_q;

   for (genvar g = 0; g < SW; g++) begin : g_stage
      if (g == 0) begin : g_first
         // When not stalled in_ready is high, so in_valid alone means a
         // transfer; when stalled the stage holds and ignores this value.
         assign src_v[g] = in_valid;
         assign src_d[g] = in_data;
         assign src_a[g] = in_amt;
         assign src_m[g] = in_mode;
         assign src_s[g] = in_data[WIDTH-1];
      end else begin : g_rest
         assign src_v[g] = v_q[g-1];
         assign src_d[g] = d_q[g-1];
         assign src_a[g] = a_q[g-1];
         assign src_m[g] = m_q[g-1];
         assign src_s[g] = s_q[g-1];
      end
      assign nxt_d[g] = src_a[g][g] ? shift_step(src_d[g], src_m[g], src_s[g], 1 << g)
                                    : src_d[g];
   end

   // Pipeline advance: reset clears everything, flush kills all valid bits
   // (even while stalled), otherwise every stage moves forward unless stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SW; i++) begin
            v_q[i] <= 1'b0;
            d_q[i] <= '0;
            a_q[i] <= '0;
            m_q[i] <= '0;
            s_q[i] <= 1'b0;
         end
         z_q <= 1'b0;
      end else if (flush) begin
         for (int i = 0; i < SW; i++) begin
            v_q[i] <= 1'b0;
         end
      end else if (!stall) begin
         for (int i = 0; i < SW; i++) begin
            v_q[i] <= src_v[i];
            d_q[i] <= nxt_d[i];
            a_q[i] <= src_a[i];
            m_q[i] <= src_m[i];
            s_q[i] <= src_s[i];
         end
         z_q <= (nxt_d[SW-1] == '0);
      end
   end

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: directed and exhaustive checks of pipelined_shifter
// at WIDTH=8. Expected results come from a reference model written with the
// plain shift operators, held in an expected queue in acceptance order.
// Honors PIPELINED_SHIFTER_ROTATE_EN the same way the design does.

module tb_pipelined_shifter;

   localparam int W  = 8;
   localparam int SW = 3;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [SW-1:0] in_amt;
   logic [1:0]    in_mode;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic          out_zero;

   int n_tests = 0;
   int n_fail  = 0;
   int n_out   = 0;

   logic [W-1:0] exp_q[$];

   pipelined_shifter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_zero  (out_zero)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: shift by the whole amount in one go.
   function automatic logic [W-1:0] model(input logic [W-1:0] d, input int a, input logic [1:0] m);
      logic [W-1:0] r;
      case (m)
         2'd0: r = d >> a;
         2'd1: r = d << a;
         2'd2: r = $signed(d) >>> a;
         default: begin
`ifdef PIPELINED_SHIFTER_ROTATE_EN
            r = (d >> a) | (d << (W - a));
`else
            r = d >> a;
`endif
         end
      endcase
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard: record accepted operands, compare delivered results
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            check("unexpected_out", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
               logic [W-1:0] e;
               e = exp_q.pop_front();
               check("sb_data", 64'(out_data), 64'(e));
               check("sb_zero", 64'(out_zero), 64'(e == '0));
               n_out++;
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(in_data, int'(in_amt), in_mode));
         if (flush) exp_q.delete();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [W-1:0] d, input logic [SW-1:0] a, input logic [1:0] m);
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      in_mode  = m;
   endtask

   // One operand into an empty pipe; out_valid must rise on the SW-th rising
   // edge counting the accept edge, and not before.
   task automatic directed(input string tag, input logic [W-1:0] d, input logic [SW-1:0] a,
                           input logic [1:0] m, input logic [W-1:0] exp);
      out_ready = 1'b1;
      present(d, a, m);
      tick();
      in_valid = 1'b0;
      check({tag, "_lat1"}, 64'(out_valid), 64'(0));
      tick();
      check({tag, "_lat2"}, 64'(out_valid), 64'(0));
      tick();
      check({tag, "_valid"}, 64'(out_valid), 64'(1));
      check({tag, "_data"}, 64'(out_data), 64'(exp));
      check({tag, "_zero"}, 64'(out_zero), 64'(exp == '0));
      tick();
   endtask

   task automatic drain();
      int c;
      c = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && c < 50) begin
         tick();
         c++;
      end
      check("drain_timeout", 64'(c < 50), 64'(1));
   endtask

   initial begin
      logic [W-1:0]  bd [5];
      logic [SW-1:0] ba [5];
      logic [1:0]    bm [5];
      logic [W-1:0]  first_exp;
      int            n0;
      int            idx;
      int            cyc;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
      in_amt = '0; in_mode = '0; out_ready = 1'b1;
      #12;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_out_zero", 64'(out_zero), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      tick();
      rst_n = 1'b1;
      tick();

      // directed modes
      directed("lsr_f0_3", 8'hF0, 3'd3, 2'b00, 8'h1E);
      directed("lsl_81_1", 8'h81, 3'd1, 2'b01, 8'h02);
      directed("asr_90_2", 8'h90, 3'd2, 2'b10, 8'hE4);
      directed("asr_70_7", 8'h70, 3'd7, 2'b10, 8'h00);
      directed("amt0_lsl", 8'hA5, 3'd0, 2'b01, 8'hA5);
      directed("amt0_asr", 8'h96, 3'd0, 2'b10, 8'h96);
`ifdef PIPELINED_SHIFTER_ROTATE_EN
      directed("ror_81_1", 8'h81, 3'd1, 2'b11, 8'hC0);
`else
      directed("ror_81_1", 8'h81, 3'd1, 2'b11, 8'h40);
`endif

      // backpressure: 5 back-to-back, out_ready low 4 cycles after first result
      for (int k = 0; k < 5; k++) begin
         bd[k] = 8'($urandom);
         ba[k] = 3'($urandom_range(1, 7));
         bm[k] = 2'($urandom_range(0, 3));
      end
      first_exp = model(bd[0], int'(ba[0]), bm[0]);
      n0 = n_out;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         present(bd[k], ba[k], bm[k]);
         tick();
      end
      check("bp_first_valid", 64'(out_valid), 64'(1));
      present(bd[3], ba[3], bm[3]);
      out_ready = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         check("bp_in_ready", 64'(in_ready), 64'(0));
         check("bp_hold_valid", 64'(out_valid), 64'(1));
         check("bp_hold_data", 64'(out_data), 64'(first_exp));
         tick();
      end
      out_ready = 1'b1;
      tick();
      present(bd[4], ba[4], bm[4]);
      tick();
      drain();
      check("bp_count", 64'(n_out - n0), 64'(5));

      // flush together with a new transfer: nothing in flight may emerge
      n0 = n_out;
      present(8'h11, 3'd1, 2'b00);
      tick();
      present(8'h22, 3'd2, 2'b01);
      tick();
      present(8'h33, 3'd3, 2'b10);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("flush_no_valid", 64'(out_valid), 64'(0));
         tick();
      end
      check("flush_count", 64'(n_out - n0), 64'(0));
      directed("post_flush", 8'hF0, 3'd4, 2'b00, 8'h0F);

      // flush while stalled
      n0 = n_out;
      for (int k = 0; k < 3; k++) begin
         present(8'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();
      check("stall_flush_pre", 64'(out_valid), 64'(1));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("stall_flush_no_valid", 64'(out_valid), 64'(0));
         tick();
      end
      check("stall_flush_count", 64'(n_out - n0), 64'(0));

      // reset with 3 entries in flight
      n0 = n_out;
      for (int k = 0; k < 3; k++) begin
         present(8'($urandom_range(1, 255)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'(0));
      check("mid_rst_out_data", 64'(out_data), 64'(0));
      check("mid_rst_in_ready", 64'(in_ready), 64'(1));
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         check("post_rst_no_valid", 64'(out_valid), 64'(0));
         tick();
      end
      check("post_rst_count", 64'(n_out - n0), 64'(0));

      // exhaustive sweep: all data x amt x mode with random out_ready
      n0  = n_out;
      idx = 0;
      cyc = 0;
      while (idx < 256 * 8 * 4 && cyc < 40000) begin
         present(8'(idx), 3'(idx >> 8), 2'(idx >> 11));
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (in_ready) idx++;
         tick();
         cyc++;
      end
      check("sweep_timeout", 64'(cyc < 40000), 64'(1));
      drain();
      check("sweep_count", 64'(n_out - n0), 64'(256 * 8 * 4));
      check("sweep_queue_empty", 64'(exp_q.size()), 64'(0));

      if (n_fail == 0) $display("[TB] exhaustive sweep PASSED");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
